// File: rtl/qpsk_demod.sv
// Hard-decision QPSK demapper: slices the sign bits of an equalised complex symbol
// and delivers them through a 2-entry output FIFO on a Wishbone-style stream.
module qpsk_demod #(
  parameter int IQ_W  = 16,
  parameter int OUT_W = 6
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic [2*IQ_W-1:0] DAT_I,
  input  logic              CYC_I,
  input  logic              STB_I,
  input  logic              WE_I,
  output logic              ACK_O,
  output logic [OUT_W-1:0]  DAT_O,
  output logic              CYC_O,
  output logic              STB_O,
  output logic              WE_O,
  input  logic              ACK_I
);

  logic [1:0]       r_count;
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_mem [2];
  logic             r_stb;
  logic             r_cyc;
  logic [OUT_W-1:0] r_dat;

  logic             w_push;
  logic             w_pop;
  logic [1:0]       w_sym;
  logic [1:0]       w_count_next;
  logic             w_rptr_next;
  logic [1:0]       w_mem_next [2];
  logic [1:0]       w_head;
  logic             w_cyc_next;
  logic             w_unused;

  // Only the sign bits matter for a hard QPSK decision; exactly zero slices to 1.
  assign w_sym    = {~DAT_I[2*IQ_W-1], ~DAT_I[IQ_W-1]};
  assign w_unused = ^{DAT_I[2*IQ_W-2:IQ_W], DAT_I[IQ_W-2:0]};

  assign ACK_O  = CYC_I & STB_I & WE_I & (r_count != 2'd2);
  assign w_push = ACK_O;
  assign w_pop  = r_stb & ACK_I;

  always_comb begin
    w_mem_next[0] = r_mem[0];
    w_mem_next[1] = r_mem[1];
    if (w_push) begin
      w_mem_next[r_wptr] = w_sym;
    end
  end

  always_comb begin
    w_count_next = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 2'd1;
      2'b01:   w_count_next = r_count - 2'd1;
      default: w_count_next = r_count;
    endcase
  end

  assign w_rptr_next = r_rptr ^ w_pop;
  // Head is taken from the post-write storage so an empty FIFO forwards in one cycle.
  assign w_head      = w_mem_next[w_rptr_next];

  always_comb begin
    w_cyc_next = r_cyc;
    if (w_push) begin
      w_cyc_next = 1'b1;
    end else if (!CYC_I && (w_count_next == 2'd0)) begin
      w_cyc_next = 1'b0;
    end
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_count  <= 2'd0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_mem[0] <= 2'd0;
      r_mem[1] <= 2'd0;
      r_stb    <= 1'b0;
      r_cyc    <= 1'b0;
      r_dat    <= '0;
    end else begin
      r_count  <= w_count_next;
      r_wptr   <= r_wptr ^ w_push;
      r_rptr   <= w_rptr_next;
      r_mem[0] <= w_mem_next[0];
      r_mem[1] <= w_mem_next[1];
      r_stb    <= (w_count_next != 2'd0);
      r_cyc    <= w_cyc_next;
      r_dat    <= (w_count_next != 2'd0) ? {{(OUT_W-2){1'b0}}, w_head} : '0;
    end
  end

  assign STB_O = r_stb;
  assign WE_O  = r_stb;
  assign CYC_O = r_cyc;
  assign DAT_O = r_dat;

endmodule
